// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL acquisition controller.
// Coarse VCO band search from PFD UP/DN statistics, then fine-loop tracking
// until the lock detector reports lock, with timeout retries and loss-of-lock
// supervision. All outputs are registered.
// Build option: define PLLSEQ_AUTO_RELOCK_EN to re-enter tracking on loss of
// lock (band kept) instead of declaring failure.
module pll_lock_sequencer #(
    parameter int BAND_W    = 4,
    parameter int BAND_INIT = 8,
    parameter int SETTLE    = 64,
    parameter int WINDOW    = 256,
    parameter int MARGIN    = 8,
    parameter int LOCK_TO   = 4096,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              up,
    input  logic              dn,
    input  logic              locked,
    output logic [BAND_W-1:0] band,
    output logic              loop_en,
    output logic              det_clr,
    output logic              ready,
    output logic              fail,
    output logic              lost_lock,
    output logic [2:0]        state
);

    // One shared timer serves settle, measurement window and track timeout.
    localparam int TMAX  = (LOCK_TO > WINDOW) ? ((LOCK_TO > SETTLE) ? LOCK_TO : SETTLE)
                                              : ((WINDOW > SETTLE) ? WINDOW : SETTLE);
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int CMP_W = $clog2(WINDOW + MARGIN + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_TRACK   = 3'd3,
        S_LOCKED  = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    state_t             state_reg, state_next;
    logic [BAND_W-1:0]  band_reg, band_next;
    logic               loop_en_reg, loop_en_next;
    logic               det_clr_reg, det_clr_next;
    logic               ready_reg, ready_next;
    logic               fail_reg, fail_next;
    logic               lost_lock_reg, lost_lock_next;
    logic [TMR_W-1:0]   tmr_reg, tmr_next;
    logic [CNT_W-1:0]   up_cnt_reg, up_cnt_next;
    logic [CNT_W-1:0]   dn_cnt_reg, dn_cnt_next;
    logic [RTY_W-1:0]   retry_reg, retry_next;
    dir_t               prev_dir_reg, prev_dir_next;

    // Running totals including the current cycle's sample, so the last
    // window cycle is counted in the decision.
    logic [CMP_W-1:0]   up_sum, dn_sum;
    logic [RTY_W-1:0]   retry_inc;
    dir_t               meas_dir;
    logic               go_track;

    assign up_sum    = CMP_W'(up_cnt_reg) + CMP_W'(up);
    assign dn_sum    = CMP_W'(dn_cnt_reg) + CMP_W'(dn);
    assign retry_inc = retry_reg + RTY_W'(1);

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            band_reg      <= BAND_W'(BAND_INIT);
            loop_en_reg   <= 1'b0;
            det_clr_reg   <= 1'b0;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
            lost_lock_reg <= 1'b0;
            tmr_reg       <= '0;
            up_cnt_reg    <= '0;
            dn_cnt_reg    <= '0;
            retry_reg     <= '0;
            prev_dir_reg  <= DIR_NONE;
        end else begin
            state_reg     <= state_next;
            band_reg      <= band_next;
            loop_en_reg   <= loop_en_next;
            det_clr_reg   <= det_clr_next;
            ready_reg     <= ready_next;
            fail_reg      <= fail_next;
            lost_lock_reg <= lost_lock_next;
            tmr_reg       <= tmr_next;
            up_cnt_reg    <= up_cnt_next;
            dn_cnt_reg    <= dn_cnt_next;
            retry_reg     <= retry_next;
            prev_dir_reg  <= prev_dir_next;
        end
    end

    // Next-state and next-output decisions for the acquisition sequence.
    always_comb begin
        state_next     = state_reg;
        band_next      = band_reg;
        loop_en_next   = loop_en_reg;
        det_clr_next   = 1'b0;
        ready_next     = ready_reg;
        fail_next      = fail_reg;
        lost_lock_next = 1'b0;
        tmr_next       = tmr_reg;
        up_cnt_next    = up_cnt_reg;
        dn_cnt_next    = dn_cnt_reg;
        retry_next     = retry_reg;
        prev_dir_next  = prev_dir_reg;
        meas_dir       = DIR_NONE;
        go_track       = 1'b0;

        case (state_reg)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    state_next    = S_SETTLE;
                    band_next     = BAND_W'(BAND_INIT);
                    retry_next    = '0;
                    fail_next     = 1'b0;
                    ready_next    = 1'b0;
                    loop_en_next  = 1'b0;
                    prev_dir_next = DIR_NONE;
                    tmr_next      = '0;
                end
            end
            S_SETTLE: begin
                loop_en_next = 1'b0;
                up_cnt_next  = '0;
                dn_cnt_next  = '0;
                if (tmr_reg == TMR_W'(SETTLE - 1)) begin
                    state_next = S_MEASURE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_MEASURE: begin
                up_cnt_next = up_sum[CNT_W-1:0];
                dn_cnt_next = dn_sum[CNT_W-1:0];
                if (tmr_reg == TMR_W'(WINDOW - 1)) begin
                    tmr_next = '0;
                    if (up_sum > dn_sum + CMP_W'(MARGIN)) begin
                        meas_dir = DIR_UP;
                    end else if (dn_sum > up_sum + CMP_W'(MARGIN)) begin
                        meas_dir = DIR_DN;
                    end
                    // Centred, bracketed (direction reversed) or band at its
                    // limit: stop searching and hand over to the fine loop.
                    go_track = (meas_dir == DIR_NONE)
                            || (meas_dir == DIR_UP && prev_dir_reg == DIR_DN)
                            || (meas_dir == DIR_DN && prev_dir_reg == DIR_UP)
                            || (meas_dir == DIR_UP && band_reg == '1)
                            || (meas_dir == DIR_DN && band_reg == '0);
                    if (go_track) begin
                        state_next   = S_TRACK;
                        loop_en_next = 1'b1;
                        det_clr_next = 1'b1;
                    end else begin
                        state_next    = S_SETTLE;
                        band_next     = (meas_dir == DIR_UP) ? band_reg + BAND_W'(1)
                                                             : band_reg - BAND_W'(1);
                        prev_dir_next = meas_dir;
                    end
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_TRACK: begin
                if (locked) begin
                    state_next   = S_LOCKED;
                    ready_next   = 1'b1;
                    loop_en_next = 1'b1;
                end else if (tmr_reg == TMR_W'(LOCK_TO - 1)) begin
                    tmr_next     = '0;
                    retry_next   = retry_inc;
                    loop_en_next = 1'b0;
                    if (retry_inc == RTY_W'(MAX_RETRY)) begin
                        state_next = S_FAIL;
                        fail_next  = 1'b1;
                    end else begin
                        state_next    = S_SETTLE;
                        band_next     = BAND_W'(BAND_INIT);
                        prev_dir_next = DIR_NONE;
                    end
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_LOCKED: begin
                loop_en_next = 1'b1;
                if (!locked) begin
                    lost_lock_next = 1'b1;
                    ready_next     = 1'b0;
`ifdef PLLSEQ_AUTO_RELOCK_EN
                    state_next     = S_TRACK;
                    det_clr_next   = 1'b1;
                    tmr_next       = '0;
`else
                    state_next     = S_FAIL;
                    fail_next      = 1'b1;
                    loop_en_next   = 1'b0;
`endif
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign band      = band_reg;
    assign loop_en   = loop_en_reg;
    assign det_clr   = det_clr_reg;
    assign ready     = ready_reg;
    assign fail      = fail_reg;
    assign lost_lock = lost_lock_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed and randomized acquisition
// scenarios checked against a band-search model derived from the PFD counts.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int BAND_INIT = 8;
    localparam int SETTLE    = 64;
    localparam int WINDOW    = 256;
    localparam int MARGIN    = 8;
    localparam int LOCK_TO   = 4096;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       locked = 1'b0;
    logic [3:0] band;
    logic       loop_en, det_clr, ready, fail, lost_lock;
    logic [2:0] state;

    int compared = 0;
    int mismatched = 0;

    // Reference model: current band, last search direction (-1/0/+1), retries.
    int m_band;
    int m_prev;
    int m_retry;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .BAND_W(4), .BAND_INIT(BAND_INIT), .SETTLE(SETTLE), .WINDOW(WINDOW),
        .MARGIN(MARGIN), .LOCK_TO(LOCK_TO), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .up(up), .dn(dn), .locked(locked),
        .band(band), .loop_en(loop_en), .det_clr(det_clr), .ready(ready),
        .fail(fail), .lost_lock(lost_lock), .state(state)
    );

    // Inputs change at negedge; outputs are read at the negedge after a posedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Spec-level search rule applied to one window's totals.
    task automatic model_decide(input int uc, input int dc, output bit trk);
        int dir;
        dir = 0;
        if (uc > dc + MARGIN) dir = 1;
        else if (dc > uc + MARGIN) dir = -1;
        if (dir == 0 || dir == -m_prev || (dir == 1 && m_band == 15) || (dir == -1 && m_band == 0)) begin
            trk = 1'b1;
        end else begin
            m_band = m_band + dir;
            m_prev = dir;
            trk = 1'b0;
        end
    endtask

    // Pulse counts per window for each scenario.
    task automatic counts_for(input int mode, output int u, output int d);
        int kind;
        u = 10; d = 10;
        case (mode)
            1: begin if (m_band < 11) begin u = 200; d = 0; end else begin u = 5; d = 5; end end
            2: begin if (m_prev == 0) begin u = 200; d = 0; end else begin u = 0; d = 200; end end
            3: begin u = 256; d = 0; end
            4: begin
                kind = int'($urandom_range(0, 1));
                if (kind == 0) begin
                    u = int'($urandom_range(0, WINDOW));
                    d = int'($urandom_range(0, WINDOW));
                end else begin
                    u = int'($urandom_range(20, 200));
                    d = u + int'($urandom_range(0, 2 * MARGIN + 2)) - (MARGIN + 1);
                end
            end
            5: begin if (m_band == BAND_INIT && m_prev == 0) begin u = 200; d = 0; end else begin u = 5; d = 5; end end
            default: begin u = 10; d = 10; end
        endcase
    endtask

    // One SETTLE + MEASURE round with exactly u_n UP and d_n DN pulses placed randomly.
    task automatic run_round(input int u_n, input int d_n, output bit trk);
        int ur, dr, uc, dc;
        logic [2:0] exp_state;
        for (int i = 0; i < SETTLE; i++) begin
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 7) == 0);
            step();
            if (i == SETTLE - 2) begin
                compared++;
                if (state !== 3'd1 || loop_en !== 1'b0) begin
                    mismatched++;
                    $display("FAIL settle_hold: state=%0d loop_en=%0b, want state=1 loop_en=0", state, loop_en);
                end
            end
        end
        start = 1'b0;
        compared++;
        if (state !== 3'd2) begin
            mismatched++;
            $display("FAIL settle_length: state=%0d, want 2", state);
        end
        ur = u_n; dr = d_n; uc = 0; dc = 0;
        for (int i = 0; i < WINDOW; i++) begin
            up = ($urandom_range(0, WINDOW - 1 - i) < ur);
            dn = ($urandom_range(0, WINDOW - 1 - i) < dr);
            if (up) ur--;
            if (dn) dr--;
            uc += int'(up);
            dc += int'(dn);
            step();
            if (i == WINDOW - 2) begin
                compared++;
                if (state !== 3'd2) begin
                    mismatched++;
                    $display("FAIL window_hold: state=%0d, want 2", state);
                end
            end
        end
        up = 1'b0; dn = 1'b0;
        model_decide(uc, dc, trk);
        exp_state = trk ? 3'd3 : 3'd1;
        compared++;
        if (state !== exp_state || band !== 4'(m_band) || det_clr !== trk || loop_en !== trk) begin
            mismatched++;
            $display("FAIL round_decision: up=%0d dn=%0d got state=%0d band=%0d det_clr=%0b loop_en=%0b, want state=%0d band=%0d det_clr=%0b loop_en=%0b",
                     uc, dc, state, band, det_clr, loop_en, exp_state, m_band, trk, trk);
        end
        $display("round: up=%0d dn=%0d -> state=%0d band=%0d", uc, dc, state, band);
    endtask

    // Repeat rounds until the model hands over to tracking (bounded).
    task automatic acquire(input int mode, output int n_rounds);
        int u, d;
        bit trk;
        trk = 1'b0;
        n_rounds = 0;
        while (!trk && n_rounds < 20) begin
            counts_for(mode, u, d);
            run_round(u, d, trk);
            n_rounds++;
        end
        compared++;
        if (!trk) begin
            mismatched++;
            $display("FAIL acquire_bound: no TRACK after %0d rounds, want TRACK within 20", n_rounds);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; up = 1'b0; dn = 1'b0; locked = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic start_acq();
        m_band = BAND_INIT; m_prev = 0; m_retry = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        compared++;
        if (state !== 3'd1 || band !== 4'(BAND_INIT) || fail !== 1'b0) begin
            mismatched++;
            $display("FAIL start_accept: state=%0d band=%0d fail=%0b, want state=1 band=8 fail=0", state, band, fail);
        end
    endtask

    task automatic wait_lock(input int delay);
        locked = 1'b0;
        for (int i = 0; i < delay; i++) begin
            step();
            if (i == 0) begin
                compared++;
                if (det_clr !== 1'b0) begin
                    mismatched++;
                    $display("FAIL det_clr_width: det_clr=%0b one cycle into TRACK, want 0", det_clr);
                end
            end
        end
        compared++;
        if (state !== 3'd3 || ready !== 1'b0) begin
            mismatched++;
            $display("FAIL track_wait: state=%0d ready=%0b, want state=3 ready=0", state, ready);
        end
        locked = 1'b1;
        step();
        compared++;
        if (state !== 3'd4 || ready !== 1'b1 || loop_en !== 1'b1) begin
            mismatched++;
            $display("FAIL lock_enter: state=%0d ready=%0b loop_en=%0b, want 4/1/1", state, ready, loop_en);
        end
        $display("lock: after %0d cycles state=%0d ready=%0b", delay, state, ready);
    endtask

    task automatic drop_lock();
        locked = 1'b0;
        step();
        compared++;
        if (lost_lock !== 1'b1 || ready !== 1'b0) begin
            mismatched++;
            $display("FAIL lost_lock_pulse: lost_lock=%0b ready=%0b, want 1/0", lost_lock, ready);
        end
        compared++;
`ifdef PLLSEQ_AUTO_RELOCK_EN
        if (state !== 3'd3 || det_clr !== 1'b1 || loop_en !== 1'b1 || fail !== 1'b0 || band !== 4'(m_band)) begin
            mismatched++;
            $display("FAIL relock_entry: state=%0d det_clr=%0b loop_en=%0b fail=%0b band=%0d, want 3/1/1/0/%0d",
                     state, det_clr, loop_en, fail, band, m_band);
        end
`else
        if (state !== 3'd5 || fail !== 1'b1 || loop_en !== 1'b0) begin
            mismatched++;
            $display("FAIL loss_to_fail: state=%0d fail=%0b loop_en=%0b, want 5/1/0", state, fail, loop_en);
        end
`endif
        step();
        compared++;
        if (lost_lock !== 1'b0 || det_clr !== 1'b0) begin
            mismatched++;
            $display("FAIL lost_lock_width: lost_lock=%0b det_clr=%0b, want 0/0", lost_lock, det_clr);
        end
        $display("loss: state=%0d fail=%0b", state, fail);
    endtask

    // One full TRACK timeout with locked held low.
    task automatic timeout_attempt();
        logic [2:0] exp_state;
        locked = 1'b0;
        repeat (LOCK_TO - 1) step();
        compared++;
        if (state !== 3'd3) begin
            mismatched++;
            $display("FAIL timeout_early: state=%0d after %0d TRACK cycles, want 3", state, LOCK_TO - 1);
        end
        step();
        m_retry++;
        if (m_retry == MAX_RETRY) begin
            exp_state = 3'd5;
        end else begin
            exp_state = 3'd1;
            m_band = BAND_INIT;
            m_prev = 0;
        end
        compared++;
        if (state !== exp_state || band !== 4'(m_band) || loop_en !== 1'b0 || ready !== 1'b0 ||
            fail !== (m_retry == MAX_RETRY)) begin
            mismatched++;
            $display("FAIL timeout_action: retry=%0d state=%0d band=%0d loop_en=%0b fail=%0b, want state=%0d band=%0d",
                     m_retry, state, band, loop_en, fail, exp_state, m_band);
        end
        $display("timeout: retry=%0d state=%0d band=%0d", m_retry, state, band);
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (state !== 3'd0 || band !== 4'd8 || loop_en !== 1'b0 || det_clr !== 1'b0 ||
            ready !== 1'b0 || fail !== 1'b0 || lost_lock !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_initial: state=%0d band=%0d loop_en=%0b ready=%0b fail=%0b, want 0/8/0/0/0",
                     state, band, loop_en, ready, fail);
        end
        start_acq();
        for (int i = 0; i < SETTLE + 100; i++) begin
            up = 1'($urandom_range(0, 1));
            step();
        end
        compared++;
        if (state !== 3'd2) begin
            mismatched++;
            $display("FAIL reset_setup: state=%0d, want 2 before mid-window reset", state);
        end
        do_reset();
        compared++;
        if (state !== 3'd0 || band !== 4'd8 || loop_en !== 1'b0 || ready !== 1'b0 || fail !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_measure: state=%0d band=%0d loop_en=%0b ready=%0b fail=%0b, want 0/8/0/0/0",
                     state, band, loop_en, ready, fail);
        end
        repeat (5) step();
        compared++;
        if (state !== 3'd0) begin
            mismatched++;
            $display("FAIL idle_hold: state=%0d without start, want 0", state);
        end
        $display("reset: state=%0d band=%0d", state, band);
    endtask

    task automatic test_centred();
        int n;
        do_reset();
        start_acq();
        acquire(0, n);
        compared++;
        if (band !== 4'd8 || n != 1) begin
            mismatched++;
            $display("FAIL centred: band=%0d rounds=%0d, want band=8 rounds=1", band, n);
        end
        wait_lock(100);
    endtask

    task automatic test_search_up();
        int n;
        do_reset();
        start_acq();
        acquire(1, n);
        compared++;
        if (band !== 4'd11 || n != 4 || state !== 3'd3) begin
            mismatched++;
            $display("FAIL search_up: band=%0d rounds=%0d state=%0d, want band=11 rounds=4 state=3", band, n, state);
        end
    endtask

    task automatic test_bracket();
        int n;
        do_reset();
        start_acq();
        acquire(2, n);
        compared++;
        if (band !== 4'd9 || n != 2) begin
            mismatched++;
            $display("FAIL bracket: band=%0d rounds=%0d, want band=9 rounds=2", band, n);
        end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        start_acq();
        acquire(3, n);
        compared++;
        if (band !== 4'd15 || n != 8 || state !== 3'd3) begin
            mismatched++;
            $display("FAIL saturate: band=%0d rounds=%0d state=%0d, want band=15 rounds=8 state=3", band, n, state);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        start_acq();
        acquire(5, n);
        timeout_attempt();
        acquire(0, n);
        timeout_attempt();
        acquire(0, n);
        timeout_attempt();
        repeat (10) step();
        compared++;
        if (state !== 3'd5 || fail !== 1'b1) begin
            mismatched++;
            $display("FAIL fail_sticky: state=%0d fail=%0b, want 5/1", state, fail);
        end
        start_acq();
    endtask

    task automatic test_lost_lock();
        int n;
        do_reset();
        start_acq();
        acquire(0, n);
        wait_lock(20);
        drop_lock();
`ifdef PLLSEQ_AUTO_RELOCK_EN
        wait_lock(30);
`else
        start_acq();
`endif
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            start_acq();
            acquire(4, n);
            wait_lock(int'($urandom_range(1, 300)));
            drop_lock();
        end
    endtask

    initial begin
        test_reset();
        test_centred();
        test_search_up();
        test_bracket();
        test_saturate();
        test_timeout();
        test_lost_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded 5 ms, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
